// File: rtl/alarm_zone_pkg.sv
// Shared types and constants for the per-zone alarm qualifier.
// Holds the zone state encoding, the register map and the counter width.
package alarm_zone_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ZS_CLEAR     = 2'd0,
    ZS_ARMING    = 2'd1,
    ZS_ALARM     = 2'd2,
    ZS_RELEASING = 2'd3
  } zone_state_e;

  localparam logic [1:0] REG_ASSERT  = 2'd0;
  localparam logic [1:0] REG_RELEASE = 2'd1;
  localparam logic [1:0] REG_ENABLE  = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // A programmed threshold of 0 is treated as 1.
  function automatic logic [CNT_W-1:0] eff_thr(input logic [CNT_W-1:0] thr);
    return (thr == '0) ? CNT_W'(1) : thr;
  endfunction

endpackage

// File: rtl/alarm_zone_filter_if.sv
// Scan-result, Avalon-MM slave and alarm output signals of the zone filter.
// The master side is the scan engine / CPU / PIO, the slave side the filter.
interface alarm_zone_filter_if #(
  parameter int ZONES = 4
) ();

  logic             scan_done;
  logic [ZONES-1:0] zone_hit;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [ZONES-1:0] alarm_out;
  logic             wdog_fault;

  modport master (
    output scan_done, zone_hit, address, chipselect, write_n, writedata,
    input  readdata, alarm_out, wdog_fault
  );

  modport slave (
    input  scan_done, zone_hit, address, chipselect, write_n, writedata,
    output readdata, alarm_out, wdog_fault
  );

endinterface

// File: rtl/alarm_zone_fsm.sv
// One alarm zone: debounce FSM with an 8-bit consecutive-scan counter.
// active_o is taken from the next state so the top's output register lines up with it.
module alarm_zone_fsm
  import alarm_zone_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan_done_i,
  input  logic             hit_i,
  input  logic [CNT_W-1:0] assert_n_i,
  input  logic [CNT_W-1:0] release_n_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic             active_o,
  output logic [CNT_W-1:0] cnt_o
);

  zone_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   a_thr;
  logic [CNT_W:0]   r_thr;

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign a_thr   = {1'b0, eff_thr(assert_n_i)};
  assign r_thr   = {1'b0, eff_thr(release_n_i)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ZS_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // Disable and acknowledge both win over a scan arriving in the same cycle.
    if (!enable_i || clear_i) begin
      state_d = ZS_CLEAR;
      cnt_d   = '0;
    end else if (scan_done_i) begin
      unique case (state_q)
        ZS_CLEAR: begin
          if (hit_i) begin
            if (a_thr == 1) begin
              state_d = ZS_ALARM;
              cnt_d   = '0;
            end else begin
              state_d = ZS_ARMING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ZS_ARMING: begin
          if (!hit_i) begin
            state_d = ZS_CLEAR;
            cnt_d   = '0;
          end else if (cnt_inc >= a_thr) begin
            state_d = ZS_ALARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        ZS_ALARM: begin
          if (!hit_i) begin
            if (r_thr == 1) begin
              state_d = ZS_CLEAR;
              cnt_d   = '0;
            end else begin
              state_d = ZS_RELEASING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ZS_RELEASING: begin
          if (hit_i) begin
            state_d = ZS_ALARM;
            cnt_d   = '0;
          end else if (cnt_inc >= r_thr) begin
            state_d = ZS_CLEAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          state_d = ZS_CLEAR;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign active_o = (state_d == ZS_ALARM) || (state_d == ZS_RELEASING);
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/alarm_zone_filter.sv
// Debounced per-zone alarm qualifier feeding the alarm PIO, with a scan-loss
// watchdog and a small Avalon-MM register file for thresholds and enables.
module alarm_zone_filter
  import alarm_zone_pkg::*;
#(
  parameter int ZONES           = 4,
  parameter int ASSERT_DEFAULT  = 3,
  parameter int RELEASE_DEFAULT = 5,
  parameter int WDOG_CYCLES     = 50_000_000
) (
  input logic                clk,
  input logic                reset_n,
  alarm_zone_filter_if.slave bus
);

  localparam logic        WDOG_EN  = (WDOG_CYCLES != 0);
  localparam logic [31:0] WDOG_LIM = 32'(WDOG_CYCLES);

  logic [CNT_W-1:0] assert_q, release_q;
  logic [ZONES-1:0] enable_q;
  logic [31:0]      readdata_q, readdata_d;
  logic [ZONES-1:0] alarm_q, alarm_d;
  logic             fault_q, fault_d;
  logic [31:0]      wdog_q, wdog_d;

  logic             wr_en;
  logic [ZONES-1:0] clear_vec;
  logic [ZONES-1:0] zone_active;
  logic [CNT_W-1:0] zone_cnt [ZONES];
  logic             unused_bits;

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign clear_vec = (wr_en && bus.address == REG_STATUS) ? bus.writedata[ZONES-1:0] : '0;

  for (genvar g = 0; g < ZONES; g++) begin : g_zone
    alarm_zone_fsm u_fsm (
      .clk         (clk),
      .reset_n     (reset_n),
      .scan_done_i (bus.scan_done),
      .hit_i       (bus.zone_hit[g]),
      .assert_n_i  (assert_q),
      .release_n_i (release_q),
      .enable_i    (enable_q[g]),
      .clear_i     (clear_vec[g]),
      .active_o    (zone_active[g]),
      .cnt_o       (zone_cnt[g])
    );
  end

  // Only zone 0's count is visible in STATUS; the rest are folded away here.
  always_comb begin
    unused_bits = ^bus.writedata[31:CNT_W];
    for (int z = 1; z < ZONES; z++) unused_bits = unused_bits ^ (^zone_cnt[z]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      assert_q  <= CNT_W'(ASSERT_DEFAULT);
      release_q <= CNT_W'(RELEASE_DEFAULT);
      enable_q  <= '1;
    end else if (wr_en) begin
      unique case (bus.address)
        REG_ASSERT:  assert_q  <= bus.writedata[CNT_W-1:0];
        REG_RELEASE: release_q <= bus.writedata[CNT_W-1:0];
        REG_ENABLE:  enable_q  <= bus.writedata[ZONES-1:0];
        default:     ;
      endcase
    end
  end

  // Watchdog counter saturates at the limit; any scan restarts it and drops the fault.
  always_comb begin
    wdog_d  = wdog_q;
    fault_d = fault_q;
    if (bus.scan_done) begin
      wdog_d  = '0;
      fault_d = 1'b0;
    end else if (WDOG_EN) begin
      if (wdog_q == WDOG_LIM) fault_d = 1'b1;
      else                    wdog_d  = wdog_q + 32'd1;
    end
  end

  always_comb begin
    readdata_d = '0;
    unique case (bus.address)
      REG_ASSERT:  readdata_d[CNT_W-1:0] = assert_q;
      REG_RELEASE: readdata_d[CNT_W-1:0] = release_q;
      REG_ENABLE:  readdata_d[ZONES-1:0] = enable_q;
      default: begin
        readdata_d[ZONES-1:0] = alarm_q;
        readdata_d[8]         = fault_q;
        readdata_d[23:16]     = zone_cnt[0];
      end
    endcase
  end

  assign alarm_d = enable_q & (fault_q ? {ZONES{1'b1}} : zone_active);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      alarm_q    <= '0;
      fault_q    <= 1'b0;
      wdog_q     <= '0;
    end else begin
      readdata_q <= readdata_d;
      alarm_q    <= alarm_d;
      fault_q    <= fault_d;
      wdog_q     <= wdog_d;
    end
  end

  assign bus.readdata   = readdata_q;
  assign bus.alarm_out  = alarm_q;
  assign bus.wdog_fault = fault_q;

endmodule

// File: tb/tb_alarm_zone_filter.sv
// Directed bench for alarm_zone_filter: debounce, thresholds, enables,
// acknowledge, watchdog and asynchronous reset.
module tb_alarm_zone_filter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  alarm_zone_filter_if #(.ZONES(4)) bus ();

  alarm_zone_filter #(
    .ZONES           (4),
    .ASSERT_DEFAULT  (3),
    .RELEASE_DEFAULT (5),
    .WDOG_CYCLES     (100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.scan_done  = 1'b0;
    bus.zone_hit   = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = '0;
  endtask

  task automatic do_reset();
    idle_bus();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic scan(input logic [3:0] hit);
    bus.scan_done = 1'b1;
    bus.zone_hit  = hit;
    tick();
    bus.scan_done = 1'b0;
    bus.zone_hit  = '0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = addr;
    bus.writedata  = data;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] addr);
    bus.address = addr;
    tick();
  endtask

  initial begin
    do_reset();
    check("reset_alarm", 32'(bus.alarm_out), 32'h0);
    check("reset_wdog", 32'(bus.wdog_fault), 32'h0);
    check("reset_readdata", bus.readdata, 32'h0);
    rd(2'd0); check("rd_assert_default", bus.readdata, 32'h3);
    rd(2'd1); check("rd_release_default", bus.readdata, 32'h5);
    rd(2'd2); check("rd_enable_default", bus.readdata, 32'hF);

    // Assert after three consecutive hits
    scan(4'b0001); check("assert_scan1", 32'(bus.alarm_out), 32'h0);
    scan(4'b0001); check("assert_scan2", 32'(bus.alarm_out), 32'h0);
    scan(4'b0001); check("assert_scan3", 32'(bus.alarm_out), 32'h1);

    // Four misses then a hit keep the alarm; five misses release it
    scan(4'b0000); check("rel_miss1", 32'(bus.alarm_out), 32'h1);
    scan(4'b0000); check("rel_miss2", 32'(bus.alarm_out), 32'h1);
    rd(2'd3);      check("status_cnt2", bus.readdata, 32'h0002_0001);
    scan(4'b0000); check("rel_miss3", 32'(bus.alarm_out), 32'h1);
    scan(4'b0000); check("rel_miss4", 32'(bus.alarm_out), 32'h1);
    scan(4'b0001); check("rel_rehit", 32'(bus.alarm_out), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      scan(4'b0000); check("rel2_miss", 32'(bus.alarm_out), 32'h1);
    end
    scan(4'b0000); check("rel2_miss5", 32'(bus.alarm_out), 32'h0);

    // ASSERT_N=0 behaves as 1
    do_reset();
    wr(2'd0, 32'h0);
    scan(4'b0100); check("thr0_one_scan", 32'(bus.alarm_out), 32'h4);
    rd(2'd0);      check("thr0_readback", bus.readdata, 32'h0);

    // Acknowledge beats a simultaneous hit scan
    do_reset();
    repeat (3) scan(4'b0010);
    check("ack_pre_alarm", 32'(bus.alarm_out), 32'h2);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd3; bus.writedata = 32'h2;
    bus.scan_done  = 1'b1; bus.zone_hit = 4'b0010;
    tick();
    idle_bus();
    check("ack_cleared", 32'(bus.alarm_out), 32'h0);
    rd(2'd3); check("ack_status", bus.readdata, 32'h0);

    // Watchdog with ENABLE=1010
    do_reset();
    wr(2'd2, 32'hA);
    repeat (99) tick();
    check("wdog_c100", 32'(bus.wdog_fault), 32'h0);
    tick();
    check("wdog_c101", 32'(bus.wdog_fault), 32'h1);
    check("wdog_c101_alarm", 32'(bus.alarm_out), 32'h0);
    tick();
    check("wdog_c102_alarm", 32'(bus.alarm_out), 32'hA);
    rd(2'd3); check("wdog_status", bus.readdata, 32'h0000_010A);
    scan(4'b0000);
    check("wdog_scan_fault", 32'(bus.wdog_fault), 32'h0);
    tick();
    check("wdog_scan_alarm", 32'(bus.alarm_out), 32'h0);

    // Lowering ASSERT_N mid-count completes on the next hit
    do_reset();
    wr(2'd0, 32'h8);
    repeat (4) scan(4'b1000);
    check("lower_pre", 32'(bus.alarm_out), 32'h0);
    wr(2'd0, 32'h2);
    scan(4'b1000); check("lower_alarm", 32'(bus.alarm_out), 32'h8);

    // Threshold write coinciding with a scan uses the old threshold
    do_reset();
    scan(4'b0001);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd0; bus.writedata = 32'h2;
    bus.scan_done  = 1'b1; bus.zone_hit = 4'b0001;
    tick();
    idle_bus();
    check("oldthr_same_cycle", 32'(bus.alarm_out), 32'h0);
    scan(4'b0001); check("oldthr_next", 32'(bus.alarm_out), 32'h1);

    // Back-to-back scan_done pulses each count
    do_reset();
    bus.scan_done = 1'b1; bus.zone_hit = 4'b0001;
    tick(); check("b2b_1", 32'(bus.alarm_out), 32'h0);
    tick(); check("b2b_2", 32'(bus.alarm_out), 32'h0);
    tick(); check("b2b_3", 32'(bus.alarm_out), 32'h1);
    idle_bus();

    // Disabled zone stays clear
    do_reset();
    wr(2'd2, 32'h0);
    repeat (3) scan(4'b1111);
    check("disabled_all", 32'(bus.alarm_out), 32'h0);

    // Asynchronous reset mid-count discards state immediately
    do_reset();
    scan(4'b0001); scan(4'b0001); scan(4'b0011);
    check("async_pre", 32'(bus.alarm_out), 32'h1);
    #2 reset_n = 1'b0;
    #1 check("async_now", 32'(bus.alarm_out), 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    scan(4'b0010); scan(4'b0010);
    check("async_cnt_lost", 32'(bus.alarm_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
